pgm_rom_loader: RTL and testbench

- Sink end of the HPS ioctl download stream.
- Accepts 16-bit words written by hps_io during ROM download and buffers them in a small FIFO.
- Maps each word to a word address in the SDRAM region selected by ioctl_index.
- Issues one write per word on a req/ack port to the SDRAM controller.
- Applies ioctl_wait back-pressure and reports completion to the PGM core reset logic.

---
 rtl/pgm_loader_pkg.sv | 36 +++
 rtl/pgm_loader_fifo.sv | 52 +++++
 rtl/pgm_rom_loader.sv | 169 ++++++++++++++++
 tb/tb_pgm_rom_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pgm_loader_pkg.sv
// Shared types and constants for the PGM ROM download sink.
// Region map, FSM state encoding and the FIFO entry layout live here so the
// top and the buffer agree on them.
package pgm_loader_pkg;

  localparam int NUM_REGIONS = 4;

  // Widest SDRAM word address an entry can carry; the top's ADDR_W must not exceed it.
  localparam int MAX_ADDR_W = 24;

  // Word base of each download region, indexed by ioctl_index.
  localparam logic [NUM_REGIONS-1:0][MAX_ADDR_W-1:0] REGION_BASE = {
    24'h80_0000,  // 3: samples
    24'h40_0000,  // 2: sprites
    24'h20_0000,  // 1: tiles
    24'h00_0000   // 0: 68k program
  };

  // Loader FSM states.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [15:0]           data;
  } fifo_entry_t;

  // True when the selector names one of the mapped regions.
  function automatic logic region_valid(input logic [7:0] index);
    return index < 8'(NUM_REGIONS);
  endfunction

endpackage

// File: rtl/pgm_loader_fifo.sv
// Synchronous FIFO of address/data entries between the ioctl side and the
// SDRAM write port. Push while full and pop while empty are ignored.
module pgm_loader_fifo
  import pgm_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fifo_entry_t              wdata,
  input  logic                     pop,
  output fifo_entry_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t        mem_q [DEPTH];
  logic [PTR_W:0]     wptr_q;
  logic [PTR_W:0]     rptr_q;
  logic               push_ok;
  logic               pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign level   = wptr_q - rptr_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[PTR_W-1:0]];

  // Pointer update; reset flushes the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/pgm_rom_loader.sv
// Sink end of the HPS ioctl ROM download stream for the PGM core.
// Buffers incoming 16-bit words, maps them into the SDRAM region chosen by
// ioctl_index and writes them out one at a time over a req/ack port.
// Optional: define PGM_ROM_LOADER_CHECKSUM_EN to build a 16-bit running sum
// of written data on the checksum output; otherwise checksum reads zero.
module pgm_rom_loader
  import pgm_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24,
  parameter int HIGH_WATER = FIFO_DEPTH - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              rom_loaded,
  output logic              region_err,
  output logic [15:0]       checksum
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic               dl_q;
  logic               dl_rise;
  logic               enter_load;
  logic               in_load;
  logic               idx_ok;
  logic               wr_push;
  logic               wr_bad;
  logic               pop;
  logic               ack_take;
  logic               region_err_q;
  logic               wait_q;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [15:0]        mem_din_q;
  logic [MAX_ADDR_W-1:0] word_addr;
  fifo_entry_t        push_entry;
  fifo_entry_t        head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               unused_addr_bits;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign in_load    = (state_q == LOAD);
  assign enter_load = (state_d == LOAD) && (state_q != LOAD);
  assign idx_ok     = region_valid(ioctl_index);

  // Byte address to word offset; anything above the address width wraps away.
  assign word_addr  = REGION_BASE[ioctl_index[1:0]] + ioctl_addr[MAX_ADDR_W:1];
  assign unused_addr_bits = ^{ioctl_addr[26:MAX_ADDR_W+1], ioctl_addr[0]};

  // A full FIFO means the host ignored ioctl_wait: drop and flag it.
  assign wr_push    = in_load & ioctl_wr & idx_ok & ~fifo_full;
  assign wr_bad     = in_load & ioctl_wr & (~idx_ok | fifo_full);
  assign pop        = ~fifo_empty & ~mem_req_q;
  assign ack_take   = mem_req_q & mem_ack;

  assign push_entry.addr = word_addr;
  assign push_entry.data = ioctl_dout;

  pgm_loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state logic for the download sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dl_rise) state_d = LOAD;
      LOAD:    if (!ioctl_download) state_d = DRAIN;
      DRAIN: begin
        // A new download resumes loading with whatever is still buffered.
        if (dl_rise) state_d = LOAD;
        else if (fifo_empty && !mem_req_q) state_d = DONE;
      end
      DONE:    if (dl_rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // State, download edge history and registered back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      wait_q  <= (fifo_level >= LVL_W'(HIGH_WATER));
    end
  end

  // Sticky error flag, cleared when a new load starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_err_q <= 1'b0;
    end else if (enter_load) begin
      region_err_q <= 1'b0;
    end else if (wr_bad) begin
      region_err_q <= 1'b1;
    end
  end

  // SDRAM write port: load the head entry, hold it until acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else if (ack_take) begin
      mem_req_q  <= 1'b0;
    end else if (pop) begin
      mem_req_q  <= 1'b1;
      mem_addr_q <= head_entry.addr[ADDR_W-1:0];
      mem_din_q  <= head_entry.data;
    end
  end

`ifdef PGM_ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running sum of acknowledged write data, restarted with each load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (enter_load) begin
      checksum_q <= '0;
    end else if (ack_take) begin
      checksum_q <= checksum_q + mem_din_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = wait_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign rom_loaded = (state_q == DONE);
  assign region_err = region_err_q;

endmodule

// File: tb/tb_pgm_rom_loader.sv
// Bench for pgm_rom_loader: an SDRAM responder checks every write against a
// queue of expected {addr, data} pairs filled as ioctl words are driven.
module tb_pgm_rom_loader;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        rom_loaded;
  logic        region_err;
  logic [15:0] checksum;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          ack_cnt = 0;
  logic        ack_hold = 1'b0;
  logic [39:0] exp_q[$];

  pgm_rom_loader u_dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .rom_loaded     (rom_loaded),
    .region_err     (region_err),
    .checksum       (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_addr(input logic [7:0] idx, input logic [26:0] baddr);
    logic [23:0] base;
    case (idx)
      8'd0:    base = 24'h000000;
      8'd1:    base = 24'h200000;
      8'd2:    base = 24'h400000;
      default: base = 24'h800000;
    endcase
    return base + baddr[24:1];
  endfunction

  // SDRAM side: ack any request at once unless held off, checking it in order.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && mem_req && !ack_hold) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_req", {24'h0, mem_addr}, 48'hFFFFFF);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check_eq("mem_wr", {8'h0, mem_addr, mem_din}, {8'h0, e});
        end
        ack_cnt++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic wr_word(input logic [7:0] idx, input logic [26:0] baddr,
                         input logic [15:0] data, input bit expect_write);
    ioctl_index = idx;
    ioctl_addr  = baddr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    if (expect_write) exp_q.push_back({exp_addr(idx, baddr), data});
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_loaded(input string tag);
    int n;
    n = 0;
    while (!rom_loaded && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, {47'h0, rom_loaded}, 48'h1);
    check_eq({tag, "_drained"}, 48'(exp_q.size()), 48'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0;
    int n_push;
    int wait_edge;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", {47'h0, mem_req}, 48'h0);
    check_eq("rst_wait", {47'h0, ioctl_wait}, 48'h0);
    check_eq("rst_loaded", {47'h0, rom_loaded}, 48'h0);
    check_eq("rst_err", {47'h0, region_err}, 48'h0);
    check_eq("rst_checksum", {32'h0, checksum}, 48'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Three words to the program region, immediate ack.
    start_dl();
    wr_word(8'd0, 27'd0, 16'h1111, 1'b1);
    wr_word(8'd0, 27'd2, 16'h2222, 1'b1);
    wr_word(8'd0, 27'd4, 16'h3333, 1'b1);
    check_eq("t1_not_loaded", {47'h0, rom_loaded}, 48'h0);
    end_dl();
    wait_loaded("t1_loaded");
    check_eq("t1_err", {47'h0, region_err}, 48'h0);
`ifdef PGM_ROM_LOADER_CHECKSUM_EN
    check_eq("t1_checksum", {32'h0, checksum}, 48'h6666);
`else
    check_eq("t1_checksum", {32'h0, checksum}, 48'h0);
`endif

    // Sprite region offset, plus an odd byte address whose low bit is ignored.
    start_dl();
    check_eq("t2_loaded_clr", {47'h0, rom_loaded}, 48'h0);
    wr_word(8'd2, 27'h10, 16'hBEEF, 1'b1);
    wr_word(8'd3, 27'h7, 16'h5A5A, 1'b1);
    wr_word(8'd1, 27'h3FF_FFFE, 16'hC0DE, 1'b1);
    end_dl();
    wait_loaded("t2_loaded");

    // Unmapped index: no write, sticky error.
    acks0 = ack_cnt;
    start_dl();
    wr_word(8'd5, 27'h20, 16'hDEAD, 1'b0);
    check_eq("t3_err_set", {47'h0, region_err}, 48'h1);
    end_dl();
    wait_loaded("t3_loaded");
    check_eq("t3_no_write", 48'(ack_cnt - acks0), 48'h0);
    check_eq("t3_err_sticky", {47'h0, region_err}, 48'h1);

    // Next download clears the error; checksum wraps.
    start_dl();
    check_eq("t4_err_clr", {47'h0, region_err}, 48'h0);
    wr_word(8'd0, 27'h100, 16'hFFFF, 1'b1);
    wr_word(8'd0, 27'h102, 16'h0002, 1'b1);
    end_dl();
    wait_loaded("t4_loaded");
`ifdef PGM_ROM_LOADER_CHECKSUM_EN
    check_eq("t4_checksum", {32'h0, checksum}, 48'h0001);
`else
    check_eq("t4_checksum", {32'h0, checksum}, 48'h0);
`endif

    // Writes outside LOAD are ignored.
    acks0 = ack_cnt;
    wr_word(8'd0, 27'h40, 16'h7777, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("t5_ignored", 48'(ack_cnt - acks0), 48'h0);

    // Back-pressure: acks held, host writes every cycle it is allowed to.
    ack_hold = 1'b1;
    start_dl();
    n_push    = 0;
    wait_edge = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (!ioctl_wait) begin
        ioctl_index = 8'd1;
        ioctl_addr  = 27'(2 * n_push);
        ioctl_dout  = 16'hA000 + 16'(n_push);
        ioctl_wr    = 1'b1;
        exp_q.push_back({exp_addr(8'd1, 27'(2 * n_push)), 16'hA000 + 16'(n_push)});
        n_push++;
      end
      @(posedge clk);
      #1;
      ioctl_wr = 1'b0;
      if (ioctl_wait && wait_edge == 0) wait_edge = cyc;
    end
    check_eq("bp_wait_edge", 48'(wait_edge), 48'd8);
    check_eq("bp_pushes", 48'(n_push), 48'd8);
    check_eq("bp_no_drop", {47'h0, region_err}, 48'h0);
    ack_hold = 1'b0;
    end_dl();
    wait_loaded("bp_loaded");
    check_eq("bp_wait_fall", {47'h0, ioctl_wait}, 48'h0);

    // Reset with a request pending and three entries buffered.
    ack_hold = 1'b1;
    start_dl();
    for (int i = 0; i < 4; i++) wr_word(8'd0, 27'(2 * i), 16'h4000 + 16'(i), 1'b0);
    check_eq("rst2_req_pending", {47'h0, mem_req}, 48'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst2_mem_req", {47'h0, mem_req}, 48'h0);
    check_eq("rst2_loaded", {47'h0, rom_loaded}, 48'h0);
    ioctl_download = 1'b0;
    reset          = 1'b0;
    ack_hold       = 1'b0;
    acks0          = ack_cnt;
    repeat (15) @(posedge clk);
    #1;
    check_eq("rst2_no_req", {47'h0, mem_req}, 48'h0);
    check_eq("rst2_no_write", 48'(ack_cnt - acks0), 48'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
